// File: rtl/step_grid_drawer_pkg.sv
// step_grid_pkg: shared types and constants for the step grid drawer.
// Holds the FSM state encoding, the default cell colours for each supported
// colour depth, and the resolution-to-coordinate-width helpers that the VGA
// top level also uses.
package step_grid_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEL  = 2'd1,
        DRAW = 2'd2
    } state_t;

    // 9-bit RGB (3 bits per channel)
    localparam logic [8:0] C9_ON   = 9'b000111000;
    localparam logic [8:0] C9_OFF  = 9'b001001001;
    localparam logic [8:0] C9_PLAY = 9'b111111000;

    // 6-bit RGB (2 bits per channel)
    localparam logic [5:0] C6_ON   = 6'b001100;
    localparam logic [5:0] C6_OFF  = 6'b010101;
    localparam logic [5:0] C6_PLAY = 6'b111100;

    // 3-bit RGB (1 bit per channel); no grey exists, so "off" is dim blue
    localparam logic [2:0] C3_ON   = 3'b010;
    localparam logic [2:0] C3_OFF  = 3'b001;
    localparam logic [2:0] C3_PLAY = 3'b110;

    function automatic logic [8:0] default_on(input int depth);
        case (depth)
            6:       return {3'b000, C6_ON};
            3:       return {6'b000000, C3_ON};
            default: return C9_ON;
        endcase
    endfunction

    function automatic logic [8:0] default_off(input int depth);
        case (depth)
            6:       return {3'b000, C6_OFF};
            3:       return {6'b000000, C3_OFF};
            default: return C9_OFF;
        endcase
    endfunction

    function automatic logic [8:0] default_play(input int depth);
        case (depth)
            6:       return {3'b000, C6_PLAY};
            3:       return {6'b000000, C3_PLAY};
            default: return C9_PLAY;
        endcase
    endfunction

    // Column coordinate width for a resolution string
    function automatic int res_nx(input logic [55:0] res);
        if (res == "320x240")      return 9;
        else if (res == "160x120") return 8;
        else                       return 10;
    endfunction

    // Row coordinate width for a resolution string
    function automatic int res_ny(input logic [55:0] res);
        if (res == "320x240")      return 8;
        else if (res == "160x120") return 7;
        else                       return 9;
    endfunction

endpackage

// File: rtl/step_grid_drawer_cell_rect_scanner.sv
// cell_rect_scanner: raster counter for one rectangular cell.
// A one-clock start latches the cell's top-left address and emits pixel
// (0,0) on the same edge; each following clock emits the next pixel in
// raster order (cx fastest). x/y/pix are registered together, so pix is a
// one-clock strobe per pixel aligned with its address. last is high while
// the final pixel of the cell is on the outputs.
module cell_rect_scanner #(
    parameter int nX     = 10,
    parameter int nY     = 9,
    parameter int CELL_W = 32,
    parameter int CELL_H = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [nX:0]   base_x,
    input  logic [nY:0]   base_y,
    output logic [nX-1:0] x,
    output logic [nY-1:0] y,
    output logic          pix,
    output logic          last
);

    localparam int CW = (CELL_W > 1) ? $clog2(CELL_W) : 1;
    localparam int CH = (CELL_H > 1) ? $clog2(CELL_H) : 1;

    logic [CW-1:0] cx, nxt_cx;
    logic [CH-1:0] cy, nxt_cy;
    logic [nX:0]   bx_q;
    logic [nY:0]   by_q;
    logic          cx_end, cy_end;

    assign cx_end = (cx == CW'(CELL_W - 1));
    assign cy_end = (cy == CH'(CELL_H - 1));
    assign last   = pix && cx_end && cy_end;

    // Next raster position: advance column, wrap into the next row
    always_comb begin
        nxt_cx = cx + 1'b1;
        nxt_cy = cy;
        if (cx_end) begin
            nxt_cx = '0;
            nxt_cy = cy + 1'b1;
        end
    end

    // Counter, latched base and registered pixel address/strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            cx   <= '0;
            cy   <= '0;
            bx_q <= '0;
            by_q <= '0;
            x    <= '0;
            y    <= '0;
            pix  <= 1'b0;
        end else if (start) begin
            cx   <= '0;
            cy   <= '0;
            bx_q <= base_x;
            by_q <= base_y;
            x    <= nX'(base_x);
            y    <= nY'(base_y);
            pix  <= 1'b1;
        end else if (pix) begin
            if (cx_end && cy_end) begin
                pix <= 1'b0;
            end else begin
                cx  <= nxt_cx;
                cy  <= nxt_cy;
                x   <= nX'(bx_q + (nX+1)'(nxt_cx));
                y   <= nY'(by_q + (nY+1)'(nxt_cy));
                pix <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/step_grid_drawer.sv
// step_grid_drawer: renders the sequencer step row as filled rectangles into
// the VGA adapter's pixel-write port, redrawing only cells whose displayed
// colour is stale. One pixel per clock; new cells are only started once the
// adapter reports the background is drawn (bg_done).
// Optional feature macro: STEP_GRID_PLAYHEAD_EN -- when defined, the cell at
// the playhead index is drawn in C_PLAY; otherwise playhead is ignored.
module step_grid_drawer
    import step_grid_pkg::*;
#(
    parameter RESOLUTION  = "640x480",
    parameter int COLOR_DEPTH = 9,
    parameter int nX          = res_nx(RESOLUTION),
    parameter int nY          = res_ny(RESOLUTION),
    parameter int NUM_STEPS   = 16,
    parameter int CELL_W      = 32,
    parameter int CELL_H      = 32,
    parameter int GAP         = 8,
    parameter int ORIGIN_X    = 4,
    parameter int ORIGIN_Y    = 224,
    parameter logic [COLOR_DEPTH-1:0] C_ON   = COLOR_DEPTH'(default_on(COLOR_DEPTH)),
    parameter logic [COLOR_DEPTH-1:0] C_OFF  = COLOR_DEPTH'(default_off(COLOR_DEPTH)),
    parameter logic [COLOR_DEPTH-1:0] C_PLAY = COLOR_DEPTH'(default_play(COLOR_DEPTH))
) (
    input  logic                         CLOCK_50,
    input  logic                         reset,
    input  logic                         bg_done,
    input  logic [NUM_STEPS-1:0]         steps,
    input  logic [$clog2(NUM_STEPS)-1:0] playhead,
    output logic [nX-1:0]                X,
    output logic [nY-1:0]                Y,
    output logic [COLOR_DEPTH-1:0]       color,
    output logic                         write,
    output logic                         busy
);

    localparam int PW    = $clog2(NUM_STEPS);
    localparam int PITCH = CELL_W + GAP;

    state_t                 state;
    logic [NUM_STEPS-1:0]   steps_q;
    logic [NUM_STEPS-1:0]   valid;
    logic [NUM_STEPS-1:0]   dirty;
    logic [COLOR_DEPTH-1:0] shown [NUM_STEPS];
    logic [COLOR_DEPTH-1:0] want  [NUM_STEPS];
    logic [PW-1:0]          sel_idx, cur_idx;
    logic [COLOR_DEPTH-1:0] sel_col, cur_col;
    logic                   any_dirty;
    logic                   start, last;
    logic [nX:0]            base_x;
    logic [nY:0]            base_y;

`ifdef STEP_GRID_PLAYHEAD_EN
    logic [PW-1:0] play_q;

    // Register the playhead alongside the step pattern
    always_ff @(posedge CLOCK_50) begin
        if (reset) play_q <= '0;
        else       play_q <= playhead;
    end
`else
    logic unused_playhead;
    assign unused_playhead = ^playhead;
`endif

    // Input stage: register the step pattern
    always_ff @(posedge CLOCK_50) begin
        if (reset) steps_q <= '0;
        else       steps_q <= steps;
    end

    // Wanted colour per cell and staleness against what is on screen
    always_comb begin
        for (int i = 0; i < NUM_STEPS; i++) begin
            want[i] = steps_q[i] ? C_ON : C_OFF;
`ifdef STEP_GRID_PLAYHEAD_EN
            if (play_q == PW'(i)) want[i] = C_PLAY;
`endif
            dirty[i] = !valid[i] || (want[i] != shown[i]);
        end
    end

    // Lowest-index dirty cell wins
    always_comb begin
        sel_idx = '0;
        for (int i = NUM_STEPS - 1; i >= 0; i--) begin
            if (dirty[i]) sel_idx = PW'(i);
        end
        any_dirty = |dirty;
        sel_col   = want[sel_idx];
    end

    // Top-left corner of the selected cell, widened by one bit then truncated
    assign base_x = (nX+1)'(ORIGIN_X) + (nX+1)'(sel_idx) * (nX+1)'(PITCH);
    assign base_y = (nY+1)'(ORIGIN_Y);

    // The scanner emits pixel (0,0) on the SEL->DRAW edge
    assign start = (state == SEL) && any_dirty;
    assign busy  = (state != IDLE);

    cell_rect_scanner #(
        .nX     (nX),
        .nY     (nY),
        .CELL_W (CELL_W),
        .CELL_H (CELL_H)
    ) u_scan (
        .clk    (CLOCK_50),
        .reset  (reset),
        .start  (start),
        .base_x (base_x),
        .base_y (base_y),
        .x      (X),
        .y      (Y),
        .pix    (write),
        .last   (last)
    );

    // Control FSM: wait for a dirty cell, select it, draw it
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state   <= IDLE;
            valid   <= '0;
            cur_idx <= '0;
            cur_col <= '0;
            color   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bg_done && any_dirty) state <= SEL;
                end
                SEL: begin
                    if (any_dirty) begin
                        cur_idx <= sel_idx;
                        cur_col <= sel_col;
                        color   <= sel_col;
                        state   <= DRAW;
                    end else begin
                        state <= IDLE;
                    end
                end
                DRAW: begin
                    if (last) begin
                        valid[cur_idx] <= 1'b1;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Record the colour of a cell once its last pixel has gone out
    always_ff @(posedge CLOCK_50) begin
        if (!reset && state == DRAW && last) shown[cur_idx] <= cur_col;
    end

endmodule

// File: tb/tb_step_grid_drawer.sv
// Directed testbench for step_grid_drawer (default geometry, 640x480, 9-bit).
module tb_step_grid_drawer;

    localparam logic [8:0] CON   = 9'b000111000;
    localparam logic [8:0] COFF  = 9'b001001001;
    localparam logic [8:0] CPLAY = 9'b111111000;

    logic       clk = 1'b0;
    logic       reset;
    logic       bg_done;
    logic [15:0] steps;
    logic [3:0] playhead;
    logic [9:0] X;
    logic [8:0] Y;
    logic [8:0] color;
    logic       write;
    logic       busy;

    int n_chk = 0;
    int n_err = 0;

    // write monitor state
    int wr_cnt, on_cnt, off_cnt, play_cnt;
    int min_x, max_x, min_y, max_y;
    int first_x, first_y, first_c, last_x, last_c;
    int x1023, y1023, x1024, y1024;

    step_grid_drawer dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .bg_done  (bg_done),
        .steps    (steps),
        .playhead (playhead),
        .X        (X),
        .Y        (Y),
        .color    (color),
        .write    (write),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (write === 1'b1) begin
            if (wr_cnt == 0) begin
                first_x = int'(X);
                first_y = int'(Y);
                first_c = int'(color);
            end
            if (wr_cnt == 1023) begin
                x1023 = int'(X);
                y1023 = int'(Y);
            end
            if (wr_cnt == 1024) begin
                x1024 = int'(X);
                y1024 = int'(Y);
            end
            last_x = int'(X);
            last_c = int'(color);
            if (int'(X) < min_x) min_x = int'(X);
            if (int'(X) > max_x) max_x = int'(X);
            if (int'(Y) < min_y) min_y = int'(Y);
            if (int'(Y) > max_y) max_y = int'(Y);
            if (color == CON)        on_cnt++;
            else if (color == COFF)  off_cnt++;
            else if (color == CPLAY) play_cnt++;
            wr_cnt++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clr_mon();
        @(posedge clk);
        #1;
        wr_cnt = 0; on_cnt = 0; off_cnt = 0; play_cnt = 0;
        min_x = 99999; max_x = -1; min_y = 99999; max_y = -1;
        first_x = -1; first_y = -1; first_c = -1; last_x = -1; last_c = -1;
        x1023 = -1; y1023 = -1; x1024 = -1; y1024 = -1;
    endtask

    task automatic wait_writes(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (wr_cnt < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        check(tag, 64'(wr_cnt >= target), 64'd1);
    endtask

    task automatic settle(input int cycles);
        repeat (cycles) @(posedge clk);
        @(negedge clk);
    endtask

`ifdef STEP_GRID_PLAYHEAD_EN
    localparam int EXP_FULL_OFF  = 15 * 1024;
    localparam int EXP_FULL_PLAY = 1024;
    localparam int EXP_RST_OFF   = 12 * 1024;
`else
    localparam int EXP_FULL_OFF  = 16 * 1024;
    localparam int EXP_FULL_PLAY = 0;
    localparam int EXP_RST_OFF   = 13 * 1024;
`endif

    initial begin
        reset = 1'b1; bg_done = 1'b0; steps = 16'h0000; playhead = 4'd0;
        clr_mon();
        repeat (3) @(posedge clk);
        #1;
        check("rst_write", 64'(write), 64'd0);
        check("rst_busy",  64'(busy),  64'd0);
        check("rst_x",     64'(X),     64'd0);
        check("rst_y",     64'(Y),     64'd0);
        check("rst_color", 64'(color), 64'd0);

        // background not ready: nothing may be written
        @(negedge clk); reset = 1'b0;
        clr_mon();
        repeat (100) @(posedge clk);
        @(negedge clk);
        check("nobg_writes", 64'(wr_cnt), 64'd0);
        check("nobg_busy",   64'(busy),   64'd0);

        // full grid draw once the background is ready
        bg_done = 1'b1;
        wait_writes(16384, 17500, "full_done");
        settle(20);
        check("full_cnt",   64'(wr_cnt),   64'd16384);
        check("full_off",   64'(off_cnt),  64'(EXP_FULL_OFF));
        check("full_play",  64'(play_cnt), 64'(EXP_FULL_PLAY));
        check("full_on",    64'(on_cnt),   64'd0);
        check("full_x0",    64'(first_x),  64'd4);
        check("full_y0",    64'(first_y),  64'd224);
        check("full_x1023", 64'(x1023),    64'd35);
        check("full_y1023", 64'(y1023),    64'd255);
        check("full_x1024", 64'(x1024),    64'd44);
        check("full_y1024", 64'(y1024),    64'd224);
        check("full_minx",  64'(min_x),    64'd4);
        check("full_maxx",  64'(max_x),    64'd635);
        check("full_miny",  64'(min_y),    64'd224);
        check("full_maxy",  64'(max_y),    64'd255);
        check("full_busy",  64'(busy),     64'd0);

        // single cell change and its latency
        clr_mon();
        @(negedge clk); steps = 16'h0008;
        @(negedge clk);
        check("lat_k_write",  64'(write), 64'd0);
        check("lat_k_busy",   64'(busy),  64'd0);
        @(negedge clk);
        check("lat_k1_write", 64'(write), 64'd0);
        check("lat_k1_busy",  64'(busy),  64'd1);
        @(negedge clk);
        check("lat_k2_write", 64'(write), 64'd1);
        check("lat_k2_x",     64'(X),     64'd124);
        check("lat_k2_y",     64'(Y),     64'd224);
        check("lat_k2_color", 64'(color), 64'(CON));
        wait_writes(1024, 1200, "c3_done");
        settle(50);
        check("c3_cnt",  64'(wr_cnt), 64'd1024);
        check("c3_on",   64'(on_cnt), 64'd1024);
        check("c3_minx", 64'(min_x),  64'd124);
        check("c3_maxx", 64'(max_x),  64'd155);
        check("c3_busy", 64'(busy),   64'd0);

        // toggle bit 5 away and back mid-draw: no second pass
        clr_mon();
        @(negedge clk); steps = 16'h0028;
        wait_writes(300, 400, "tga_mid");
        @(negedge clk); steps = 16'h0008;
        repeat (3) @(negedge clk);
        steps = 16'h0028;
        wait_writes(1024, 1200, "tga_done");
        settle(100);
        check("tga_cnt", 64'(wr_cnt),  64'd1024);
        check("tga_on",  64'(on_cnt),  64'd1024);
        check("tga_x0",  64'(first_x), 64'd204);

        // change bit 5 mid-draw and leave it: cell finishes, then is redrawn
        clr_mon();
        @(negedge clk); steps = 16'h0008;
        wait_writes(300, 400, "tgb_mid");
        @(negedge clk); steps = 16'h0028;
        wait_writes(2048, 2300, "tgb_done");
        settle(100);
        check("tgb_cnt",    64'(wr_cnt),  64'd2048);
        check("tgb_off",    64'(off_cnt), 64'd1024);
        check("tgb_on",     64'(on_cnt),  64'd1024);
        check("tgb_first",  64'(first_c), 64'(COFF));
        check("tgb_last",   64'(last_c),  64'(CON));
        check("tgb_lastx",  64'(last_x),  64'd235);

        // reset in the middle of a cell: immediate stop, then full redraw
        clr_mon();
        @(negedge clk); steps = 16'h0128;
        wait_writes(500, 600, "rmd_mid");
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        check("rmd_write", 64'(write), 64'd0);
        check("rmd_busy",  64'(busy),  64'd0);
        check("rmd_x",     64'(X),     64'd0);
        wr_cnt = 0; on_cnt = 0; off_cnt = 0; play_cnt = 0;
        @(negedge clk); reset = 1'b0;
        wait_writes(16384, 17500, "rmd_done");
        settle(20);
        check("rmd_cnt",  64'(wr_cnt),   64'd16384);
        check("rmd_on",   64'(on_cnt),   64'd3072);
        check("rmd_off",  64'(off_cnt),  64'(EXP_RST_OFF));
        check("rmd_play", 64'(play_cnt), 64'(EXP_FULL_PLAY));

`ifdef STEP_GRID_PLAYHEAD_EN
        // playhead 0 -> 3: cell 0 back to off, cell 3 becomes playhead
        clr_mon();
        @(negedge clk); playhead = 4'd3;
        wait_writes(2048, 2300, "ph3_done");
        settle(50);
        check("ph3_cnt",  64'(wr_cnt),   64'd2048);
        check("ph3_play", 64'(play_cnt), 64'd1024);
        // playhead 3 -> 4: cell 3 first (on), then cell 4 (playhead)
        clr_mon();
        @(negedge clk); playhead = 4'd4;
        wait_writes(2048, 2300, "ph4_done");
        settle(50);
        check("ph4_cnt",    64'(wr_cnt),  64'd2048);
        check("ph4_first",  64'(first_c), 64'(CON));
        check("ph4_firstx", 64'(first_x), 64'd124);
        check("ph4_last",   64'(last_c),  64'(CPLAY));
        check("ph4_lastx",  64'(last_x),  64'd195);
`else
        // playhead is ignored: sweeping it causes no drawing
        clr_mon();
        for (int p = 0; p < 16; p++) begin
            @(negedge clk); playhead = 4'(p);
            repeat (3) @(negedge clk);
        end
        settle(10);
        check("ph_writes", 64'(wr_cnt), 64'd0);
        check("ph_busy",   64'(busy),   64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/step_grid_drawer.md
# step_grid_drawer

Pixel-writer stage that sits directly upstream of `vga_adapter` and drives its `x`/`y`/`color`/`write` drawing port. It renders the sequencer's step row as filled rectangles on top of the background image. Only cells whose displayed state has changed are redrawn, at one pixel per clock. Drawing is held off until the adapter reports, via `VGA_SYNC`, that the background image has been drawn.

## Interface
Parameters:
- `RESOLUTION`, default "640x480": "640x480", "320x240" or "160x120".
- `COLOR_DEPTH`, default 9: pixel colour width, 9, 6 or 3 (RGB with equal bits per channel).
- `nX`, `nY`, default 10 / 9: coordinate widths. These are derived from `RESOLUTION` exactly as in the VGA adapter (10/9, 9/8, 8/7).
- `NUM_STEPS`, default 16: number of cells.
- `CELL_W`, `CELL_H`, default 32 / 32: cell size in pixels.
- `GAP`, default 8: horizontal pixels between cells.
- `ORIGIN_X`, `ORIGIN_Y`, default 4 / 224: top-left pixel of cell 0.
- `C_ON`, `C_OFF`, `C_PLAY`, default 9'b000111000 / 9'b001001001 / 9'b111111000: colours for an active step, an inactive step, and the playhead cell.

Ports:
- `CLOCK_50`, in, 1: sole clock.
- `reset`, in, 1: synchronous, active-high.
- `bg_done`, in, 1: connect to the adapter's `VGA_SYNC`. No pixel is written while it is low.
- `steps`, in, NUM_STEPS: step pattern. Bit i set means step i is active.
- `playhead`, in, $clog2(NUM_STEPS): current step index.
- `X`, out, nX: pixel column, to adapter `x`.
- `Y`, out, nY: pixel row, to adapter `y`.
- `color`, out, COLOR_DEPTH: to adapter `color`.
- `write`, out, 1: to adapter `write`. Asserted for one clock per pixel.
- `busy`, out, 1: high while in SEL or DRAW.

## Operation
- Input stage: `steps` and `playhead` are registered each clock into `steps_q` and `play_q`.
- Wanted colour of cell i: `C_PLAY` if i == `play_q` (see Configuration); otherwise `C_ON` if `steps_q[i]`, else `C_OFF`.
- `shown[i]` holds the colour last fully drawn for cell i. `valid[i]` marks that `shown[i]` is meaningful.
- `dirty[i]` = !`valid[i]` OR wanted(i) != `shown[i]`. This is combinational.
- The FSM has three states: IDLE, SEL and DRAW.
  - IDLE → SEL when `bg_done` is high and any `dirty` bit is set.
  - SEL (1 clock): pick the lowest-index dirty cell, latch its index and wanted colour into `cur_idx` and `cur_col`, and clear the pixel counters `cx` and `cy`. Then go to DRAW.
  - DRAW: each clock, register `X` = ORIGIN_X + `cur_idx`·(CELL_W+GAP) + `cx`, `Y` = ORIGIN_Y + `cy`, `color` = `cur_col`, and `write` = 1. Scan is raster order: `cx` increments first and wraps at CELL_W−1, then `cy` increments.
  - On the final pixel (cx = CELL_W−1, cy = CELL_H−1), write `shown[cur_idx]` = `cur_col`, set `valid[cur_idx]` = 1, and go to IDLE.
- Address arithmetic is done at width nX+1 / nY+1 and truncated to nX/nY. Parameter sets whose geometry exceeds the screen are a configuration error and are not checked at runtime.
- Input change during DRAW: the cell in progress completes with its latched colour. If it no longer matches its wanted colour, it stays dirty and is redrawn afterwards.
- `bg_done` dropping during DRAW does not abort the current cell. Only new cell selection is gated.
- Playhead movement dirties both the old cell and the new cell.

## Timing
- Reset values: `X`=0, `Y`=0, `color`=0, `write`=0, `busy`=0; state IDLE; `valid`=0, so all cells are dirty; `steps_q`=0; `play_q`=0.
- Reset asserted mid-DRAW: `write` is 0 in the clock after the reset edge, and the whole grid is redrawn afterwards.
- Latency: an input change registered at edge k gives IDLE→SEL at edge k+1, and `write` is first high after edge k+2.
- Each cell takes CELL_W·CELL_H write clocks plus 2 overhead clocks (IDLE, SEL). With defaults that is 1026 clocks per cell.
- `write` is never high in IDLE or SEL.

## Configuration
- Macro `STEP_GRID_PLAYHEAD_EN`.
- Defined: the playhead cell uses `C_PLAY`, as described above.
- Undefined: `playhead` is ignored, `play_q` and its logic are not built, and the wanted colour depends only on `steps_q`.

## Structure
- Package `step_grid_pkg` holds:
  - the FSM state enum (IDLE, SEL, DRAW);
  - default colour constants for 9-, 6- and 3-bit depths;
  - the resolution→nX/nY width functions shared with the VGA top level.
- One sub-module, `cell_rect_scanner`: the `cx`/`cy` raster counter plus X/Y address adder. It has start/last handshaking and a one-clock pixel strobe.

## Test plan
- Reset, `bg_done`=0 for 100 clocks → `write` stays 0. Raise `bg_done` with `steps`=0 → 16 cells × 1024 writes, all `color`=9'b001001001. Cell 0 spans X 4..35, Y 224..255. Then `busy` drops.
- Grid settled, set `steps`=16'h0008 → exactly 1024 writes, X 124..155, `color`=9'b000111000. First `write` comes 2 clocks after the registering edge.
- With `STEP_GRID_PLAYHEAD_EN` defined, move `playhead` 3→4 → cell 3 is redrawn first (`C_ON`), then cell 4 (`C_PLAY`); 2048 writes total.
- Toggle `steps[5]` 1→0→1 while cell 5 is mid-draw → cell 5 finishes, then is redrawn only if its final wanted colour differs from the latched one.
- Assert `reset` at pixel 500 of a cell → `write`=0 next clock, and a full 16-cell redraw follows once `bg_done` is high.
- Without `STEP_GRID_PLAYHEAD_EN`, sweep `playhead` 0..15 with `steps` constant → no writes.
